// File: rtl/cpu_pkg.sv
// cpu_pkg: state, opcode and datapath-select encodings shared by the
// multicycle controller and the datapath.
package cpu_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
    } state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV, OP_LDR, OP_STR, OP_B
    } opcode_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_ctl_t;
    typedef enum logic [1:0] {IMM_Z4, IMM_Z8, IMM_S13} imm_src_t;
    typedef enum logic [1:0] {SRCB_RD2, SRCB_IMM, SRCB_ONE} src_b_t;
    typedef enum logic [1:0] {RES_ALUOUT, RES_MEMDATA, RES_ALU} res_src_t;
    localparam logic [3:0] RD_PC = 4'd15;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: maps the opcode to the post-DECODE state and the EXEC-path
// ALU selects (MOV is ORR against R0, which the datapath reads as zero).
module instr_decoder
    import cpu_pkg::*;
(
    input  opcode_t  i_op,
    output state_t   o_next,
    output alu_ctl_t o_alu_ctl,
    output src_b_t   o_src_b,
    output imm_src_t o_imm_src
);
    assign o_next    = i_op == OP_MOV ? S_EXECI
                     : (i_op == OP_LDR || i_op == OP_STR) ? S_MEMADR
                     : i_op == OP_B ? S_BRANCH : S_EXECR;
    assign o_alu_ctl = i_op == OP_MOV ? ALU_ORR : i_op[2] ? ALU_ADD : alu_ctl_t'(i_op[1:0]);
    assign o_src_b   = i_op == OP_MOV ? SRCB_IMM : SRCB_RD2;
    assign o_imm_src = i_op == OP_MOV ? IMM_Z8 : IMM_Z4;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle control FSM for the 16-bit processor,
// with memory-ready stalls and a retired-instruction counter.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             irWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluControl,
    output logic [1:0]       immSrc,
    output logic [1:0]       resultSrc,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);
    state_t             r_state, w_next, w_dec_next;
    logic [CNT_W-1:0]   r_retired;
    opcode_t            w_op;
    alu_ctl_t           w_alu_ctl;
    src_b_t             w_src_b;
    imm_src_t           w_imm_src;
    logic               w_rd_pc, w_pc, w_ir, w_mw, w_rw, w_done, w_unused;

    assign w_op     = opcode_t'(instr[15:13]);
    assign w_rd_pc  = instr[11:8] == RD_PC;
    assign w_unused = ^{instr[12], instr[7:0]};

    instr_decoder u_dec (
        .i_op      (w_op),
        .o_next    (w_dec_next),
        .o_alu_ctl (w_alu_ctl),
        .o_src_b   (w_src_b),
        .o_imm_src (w_imm_src)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, w_done};
        end

    always_comb begin
        w_next     = r_state;
        w_pc       = 1'b0;
        w_ir       = 1'b0;
        w_mw       = 1'b0;
        w_rw       = 1'b0;
        w_done     = 1'b0;
        adrSrc     = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = SRCB_RD2;
        aluControl = ALU_ADD;
        immSrc     = IMM_Z4;
        resultSrc  = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_ONE;
                resultSrc = RES_ALU;
                w_pc      = memReady;
                w_ir      = memReady;
                w_next    = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: w_next = w_dec_next;
            S_EXECR, S_EXECI: begin
                aluSrcB    = w_src_b;
                aluControl = w_alu_ctl;
                immSrc     = w_imm_src;
                w_next     = S_ALUWB;
            end
            // Rd==PC redirects the writeback from the register file to the PC
            S_ALUWB, S_MEMWB: begin
                resultSrc = r_state == S_MEMWB ? RES_MEMDATA : RES_ALUOUT;
                w_rw      = !w_rd_pc;
                w_pc      = w_rd_pc;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMADR: begin
                aluSrcB = SRCB_IMM;
                w_next  = w_op == OP_STR ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adrSrc = 1'b1;
                w_next = memReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                adrSrc = 1'b1;
                w_mw   = 1'b1;
                w_done = memReady;
                w_next = memReady ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                aluSrcA   = 1'b1;
                aluSrcB   = SRCB_IMM;
                immSrc    = IMM_S13;
                resultSrc = RES_ALU;
                w_pc      = 1'b1;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign pcWrite  = rst_n & w_pc;
    assign irWrite  = rst_n & w_ir;
    assign memWrite = rst_n & w_mw;
    assign regWrite = rst_n & w_rw;
    assign done     = rst_n & w_done;
    assign retired  = r_retired;
    assign state    = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed plus random instructions, each expanded
// into its expected per-cycle output sequence and checked cycle by cycle.
module tb_multicycle_controller;
    import cpu_pkg::*;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, memReady = 1'b0;
    logic [15:0]   instr = '0;
    logic          pcWrite, irWrite, adrSrc, memWrite, regWrite, aluSrcA, done;
    logic [1:0]    aluSrcB, aluControl, immSrc, resultSrc;
    logic [CW-1:0] retired, exp_ret = '0;
    logic [3:0]    state;
    int            total = 0, bad = 0;

    typedef struct {logic [18:0] exp; logic rdy;} cyc_t;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .memReady(memReady),
        .pcWrite(pcWrite), .irWrite(irWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluControl(aluControl), .immSrc(immSrc), .resultSrc(resultSrc),
        .done(done), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {state, pcWrite, irWrite, adrSrc, memWrite, regWrite, aluSrcA,
                       aluSrcB, aluControl, immSrc, resultSrc, done};

    // strobes = {pcWrite, irWrite, adrSrc, memWrite, regWrite}
    function automatic logic [18:0] v(state_t s, logic [4:0] strobes, logic sa,
                                      logic [1:0] sb, logic [1:0] ac, logic [1:0] im,
                                      logic [1:0] rs, logic dn);
        return {s, strobes, sa, sb, ac, im, rs, dn};
    endfunction

    task automatic check(string tag, logic [18:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s outputs obs=%h exp=%h", tag, obs, e);
        end
        total++;
        assert (retired === exp_ret) else begin
            bad++;
            $error("FAIL %s retired obs=%0d exp=%0d", tag, retired, exp_ret);
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input int fs, input int ms, input bit kill);
        cyc_t        q[$];
        logic [2:0]  op  = ins[15:13];
        logic        r15 = ins[11:8] == 4'hF;
        logic [18:0] wb;
        for (int i = 0; i < fs; i++)
            q.push_back('{v(S_FETCH, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0), 1'b0});
        q.push_back('{v(S_FETCH, 5'b11000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0), 1'b1});
        q.push_back('{v(S_DECODE, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0), 1'($urandom)});
        if (op <= 3'd4) begin
            if (op == 3'd4)
                q.push_back('{v(S_EXECI, 5'b00000, 1'b0, 2'd1, 2'd3, 2'd1, 2'd0, 1'b0), 1'($urandom)});
            else
                q.push_back('{v(S_EXECR, 5'b00000, 1'b0, 2'd0, op[1:0], 2'd0, 2'd0, 1'b0), 1'($urandom)});
            q.push_back('{v(S_ALUWB, {r15, 3'b000, ~r15}, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1), 1'($urandom)});
        end else if (op == 3'd7) begin
            q.push_back('{v(S_BRANCH, 5'b10000, 1'b1, 2'd1, 2'd0, 2'd2, 2'd2, 1'b1), 1'($urandom)});
        end else begin
            q.push_back('{v(S_MEMADR, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0), 1'($urandom)});
            if (op == 3'd5) begin
                for (int i = 0; i <= ms; i++)
                    q.push_back('{v(S_MEMRD, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0), 1'(i == ms)});
                wb = v(S_MEMWB, {r15, 3'b000, ~r15}, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1);
                q.push_back('{wb, 1'($urandom)});
            end else begin
                for (int i = 0; i <= ms; i++)
                    q.push_back('{v(S_MEMWR, 5'b00110, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'(i == ms)), 1'(i == ms)});
            end
        end
        foreach (q[k]) begin
            @(negedge clk);
            instr    = ins;
            memReady = q[k].rdy;
            #1;
            check($sformatf("i%h_c%0d", ins, k), q[k].exp);
            if (kill && q[k].exp[18:15] == S_MEMWR && q[k].rdy) begin
                #1 rst_n = 1'b0;
                exp_ret = '0;
                #1 check("async_reset_memwr", v(S_FETCH, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
                memReady = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            exp_ret = exp_ret + {{(CW-1){1'b0}}, q[k].exp[0]};
        end
    endtask

    initial begin
        memReady = 1'b1;
        #2 check("reset_hold", v(S_FETCH, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
        @(negedge clk);
        memReady = 1'b0;
        rst_n    = 1'b1;
        run_instr(16'h0436, 0, 0, 1'b0);
        run_instr(16'h8309, 0, 0, 1'b0);
        run_instr(16'hA512, 1, 3, 1'b0);
        run_instr(16'hC512, 0, 3, 1'b0);
        run_instr(16'hE005, 0, 0, 1'b0);
        run_instr(16'h0F36, 2, 0, 1'b0);
        run_instr(16'h2123, 0, 0, 1'b0);
        run_instr(16'h4F56, 0, 0, 1'b0);
        run_instr(16'h6789, 0, 0, 1'b0);
        run_instr(16'hAF00, 0, 1, 1'b0);
        for (int n = 0; n < 60; n++)
            run_instr(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        run_instr(16'hC123, 0, 2, 1'b1);
        run_instr(16'h0436, 1, 0, 1'b0);
        run_instr(16'hC000, 0, 0, 1'b1);
        run_instr(16'h8309, 0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
